// File: rtl/wdt_reg_if_if.sv
// AXI4-Lite register bus bundle between a CPU-side master and the watchdog register slave.
// Latency: none, wires only.
// Backpressure: carried by the usual AXI valid/ready pairs on each channel.
interface wdt_reg_if_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   AWADDR;
    logic                AWVALID;
    logic                AWREADY;
    logic [DATA_W-1:0]   WDATA;
    logic [DATA_W/8-1:0] WSTRB;
    logic                WVALID;
    logic                WREADY;
    logic [1:0]          BRESP;
    logic                BVALID;
    logic                BREADY;
    logic [ADDR_W-1:0]   ARADDR;
    logic                ARVALID;
    logic                ARREADY;
    logic [DATA_W-1:0]   RDATA;
    logic [1:0]          RRESP;
    logic                RVALID;
    logic                RREADY;

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/wdt_reg_if.sv
// AXI4-Lite register front end for the watchdog core: EN/LIVE/CNT control, sticky timeout STAT/IRQ.
// Latency: AW in cycle N, W in N+1, BVALID in N+2; AR in cycle N, RVALID in N+1.
// Backpressure: B and R payloads hold stable until BREADY/RREADY; no new AW/AR accepted until then.
module wdt_reg_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    wdt_reg_if_if.slave       s_axi,
    output logic              WDEN,
    output logic              WDLIVE,
    output logic [DATA_W-1:0] WTOCNT,
    input  logic              WTO,
    output logic              IRQ
);
    localparam logic [15:0] A_EN   = 16'h0100;
    localparam logic [15:0] A_LIVE = 16'h0200;
    localparam logic [15:0] A_CNT  = 16'h0300;
    localparam logic [15:0] A_STAT = 16'h0400;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

    wstate_t           r_wstate, w_wstate_nxt;
    rstate_t           r_rstate, w_rstate_nxt;
    logic [15:0]       r_awaddr;
    logic [1:0]        r_bresp;
    logic [DATA_W-1:0] r_rdata;
    logic [1:0]        r_rresp;
    logic              r_en;
    logic              r_live;
    logic [DATA_W-1:0] r_cnt;
    logic              r_stat;

    logic              w_whs;
    logic              w_arhs;
    logic              w_hit_en, w_hit_live, w_hit_cnt, w_hit_stat, w_mapped;
    logic              w_set_bit0;
    logic [DATA_W-1:0] w_rdata;
    logic [1:0]        w_rresp;
    logic              w_unused_addr;

    // Only the low 16 address bits are decoded; the upper bits are deliberately ignored.
    assign w_unused_addr = ^{s_axi.AWADDR[ADDR_W-1:16], s_axi.ARADDR[ADDR_W-1:16]};

    assign w_whs      = (r_wstate == W_DATA) && s_axi.WVALID;
    assign w_arhs     = (r_rstate == R_IDLE) && s_axi.ARVALID;
    assign w_hit_en   = (r_awaddr == A_EN);
    assign w_hit_live = (r_awaddr == A_LIVE);
    assign w_hit_cnt  = (r_awaddr == A_CNT);
    assign w_hit_stat = (r_awaddr == A_STAT);
    assign w_mapped   = w_hit_en | w_hit_live | w_hit_cnt | w_hit_stat;
    assign w_set_bit0 = s_axi.WSTRB[0] & s_axi.WDATA[0];

    // Write FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_wstate <= W_IDLE;
        else     r_wstate <= w_wstate_nxt;
    end

    // Write FSM next state and channel handshake outputs.
    always_comb begin
        w_wstate_nxt  = r_wstate;
        s_axi.AWREADY = 1'b0;
        s_axi.WREADY  = 1'b0;
        s_axi.BVALID  = 1'b0;
        unique case (r_wstate)
            W_IDLE: begin
                s_axi.AWREADY = 1'b1;
                if (s_axi.AWVALID) w_wstate_nxt = W_DATA;
            end
            W_DATA: begin
                s_axi.WREADY = 1'b1;
                if (s_axi.WVALID) w_wstate_nxt = W_RESP;
            end
            W_RESP: begin
                s_axi.BVALID = 1'b1;
                if (s_axi.BREADY) w_wstate_nxt = W_IDLE;
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end
    assign s_axi.BRESP = r_bresp;

    // Latch write address, apply register updates and record the write response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_awaddr <= '0;
            r_bresp  <= 2'b00;
            r_en     <= 1'b0;
            r_cnt    <= '0;
        end else begin
            if ((r_wstate == W_IDLE) && s_axi.AWVALID) r_awaddr <= s_axi.AWADDR[15:0];
            if (w_whs) begin
                r_bresp <= w_mapped ? 2'b00 : 2'b11;
                if (w_hit_en && s_axi.WSTRB[0]) r_en <= s_axi.WDATA[0];
                if (w_hit_cnt) begin
                    for (int b = 0; b < DATA_W/8; b++) begin
                        if (s_axi.WSTRB[b]) r_cnt[b*8 +: 8] <= s_axi.WDATA[b*8 +: 8];
                    end
                end
            end
        end
    end

    // Kick pulse: high only in the cycle after a qualifying LIVE write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_live <= 1'b0;
        else     r_live <= w_whs & w_hit_live & w_set_bit0;
    end

    // Sticky timeout: any WTO cycle sets it, and a set beats a coincident W1C clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      r_stat <= 1'b0;
        else if (WTO) r_stat <= 1'b1;
        else if (w_whs && w_hit_stat && w_set_bit0) r_stat <= 1'b0;
    end

    // Read FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rstate <= R_IDLE;
        else     r_rstate <= w_rstate_nxt;
    end

    // Read FSM next state and channel handshake outputs.
    always_comb begin
        w_rstate_nxt  = r_rstate;
        s_axi.ARREADY = 1'b0;
        s_axi.RVALID  = 1'b0;
        unique case (r_rstate)
            R_IDLE: begin
                s_axi.ARREADY = 1'b1;
                if (s_axi.ARVALID) w_rstate_nxt = R_DATA;
            end
            R_DATA: begin
                s_axi.RVALID = 1'b1;
                if (s_axi.RREADY) w_rstate_nxt = R_IDLE;
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // Read mux over the current register values; a same-cycle write is not yet visible here.
    always_comb begin
        w_rdata = '0;
        w_rresp = 2'b00;
        case (s_axi.ARADDR[15:0])
            A_EN:    w_rdata[0] = r_en;
            A_LIVE:  w_rdata    = '0;
            A_CNT:   w_rdata    = r_cnt;
            A_STAT:  w_rdata[0] = r_stat;
            default: w_rresp    = 2'b11;
        endcase
    end

    // Capture the read payload at the AR handshake and hold it until RREADY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
            r_rresp <= 2'b00;
        end else if (w_arhs) begin
            r_rdata <= w_rdata;
            r_rresp <= w_rresp;
        end
    end

    assign s_axi.RDATA = r_rdata;
    assign s_axi.RRESP = r_rresp;
    assign WDEN        = r_en;
    assign WDLIVE      = r_live;
    assign WTOCNT      = r_cnt;
    assign IRQ         = r_stat;
endmodule

// File: tb/tb_wdt_reg_if.sv
module tb_wdt_reg_if;
    logic        clk;
    logic        rst;
    logic        WDEN;
    logic        WDLIVE;
    logic [31:0] WTOCNT;
    logic        WTO;
    logic        IRQ;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  r;
    } rexp_t;

    logic [1:0] q_bresp[$];
    rexp_t      q_rd[$];

    wdt_reg_if_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    wdt_reg_if #(.DATA_W(32), .ADDR_W(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .s_axi  (bus),
        .WDEN   (WDEN),
        .WDLIVE (WDLIVE),
        .WTOCNT (WTOCNT),
        .WTO    (WTO),
        .IRQ    (IRQ)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Full AXI write; samples core outputs the cycle after the W handshake (live0/den0/cnt0)
    // and the cycle after that (live1, only meaningful with hold == 0).
    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                      input logic [1:0] exp_resp, input int hold, input bit wto_at_w,
                      output logic live0, output logic live1, output logic den0,
                      output logic [31:0] cnt0);
        int n;
        logic [1:0] e;
        q_bresp.push_back(exp_resp);
        @(negedge clk);
        bus.AWADDR  = addr;
        bus.AWVALID = 1'b1;
        n = 0;
        while (!bus.AWREADY && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("aw_timeout", 0, 1);
        @(negedge clk);
        bus.AWVALID = 1'b0;
        bus.WDATA   = data;
        bus.WSTRB   = strb;
        bus.WVALID  = 1'b1;
        if (wto_at_w) WTO = 1'b1;
        n = 0;
        while (!bus.WREADY && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("w_timeout", 0, 1);
        @(negedge clk);
        bus.WVALID = 1'b0;
        WTO        = 1'b0;
        live0 = WDLIVE;
        den0  = WDEN;
        cnt0  = WTOCNT;
        n = 0;
        while (!bus.BVALID && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("b_timeout", 0, 1);
        e = q_bresp.pop_front();
        chk("bresp", bus.BRESP, e);
        for (int i = 0; i < hold; i++) begin
            chk("b_hold_vld", bus.BVALID, 1);
            chk("b_hold_resp", bus.BRESP, e);
            chk("aw_blocked", bus.AWREADY, 0);
            @(negedge clk);
        end
        bus.BREADY = 1'b1;
        @(negedge clk);
        bus.BREADY = 1'b0;
        live1 = WDLIVE;
        chk("b_done", bus.BVALID, 0);
        chk("aw_ready_again", bus.AWREADY, 1);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp_d, input logic [1:0] exp_r,
                      input int hold);
        int n;
        rexp_t x;
        x.d = exp_d;
        x.r = exp_r;
        q_rd.push_back(x);
        @(negedge clk);
        bus.ARADDR  = addr;
        bus.ARVALID = 1'b1;
        n = 0;
        while (!bus.ARREADY && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("ar_timeout", 0, 1);
        @(negedge clk);
        bus.ARVALID = 1'b0;
        n = 0;
        while (!bus.RVALID && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("r_timeout", 0, 1);
        x = q_rd.pop_front();
        chk("rdata", bus.RDATA, x.d);
        chk("rresp", bus.RRESP, x.r);
        for (int i = 0; i < hold; i++) begin
            chk("r_hold_vld", bus.RVALID, 1);
            chk("r_hold_data", bus.RDATA, x.d);
            chk("r_hold_resp", bus.RRESP, x.r);
            chk("ar_blocked", bus.ARREADY, 0);
            @(negedge clk);
        end
        bus.RREADY = 1'b1;
        @(negedge clk);
        bus.RREADY = 1'b0;
        chk("r_done", bus.RVALID, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        logic l0, l1, d0;
        logic [31:0] c0;
        rst = 1'b1;
        WTO = 1'b0;
        bus.AWADDR = '0; bus.AWVALID = 1'b0; bus.WDATA = '0; bus.WSTRB = '0;
        bus.WVALID = 1'b0; bus.BREADY = 1'b0; bus.ARADDR = '0; bus.ARVALID = 1'b0;
        bus.RREADY = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wden", WDEN, 0);
        chk("rst_irq", IRQ, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_wden_post", WDEN, 0);
        chk("rst_wdlive", WDLIVE, 0);
        chk("rst_wtocnt", WTOCNT, 0);
        chk("rst_irq_post", IRQ, 0);
        chk("rst_bvalid", bus.BVALID, 0);
        chk("rst_rvalid", bus.RVALID, 0);
        chk("rst_awready", bus.AWREADY, 1);
        chk("rst_arready", bus.ARREADY, 1);
        rd(32'h0100, 32'h0, 2'b00, 0);
        rd(32'h0300, 32'h0, 2'b00, 0);
        rd(32'h0400, 32'h0, 2'b00, 0);
        rd(32'h0200, 32'h0, 2'b00, 0);

        // Count and enable programming.
        wr(32'h0300, 32'h0000_0010, 4'hF, 2'b00, 0, 1'b0, l0, l1, d0, c0);
        chk("cnt_next_cycle", c0, 32'h10);
        chk("wtocnt_0x10", WTOCNT, 32'h10);
        wr(32'h0100, 32'h1, 4'hF, 2'b00, 0, 1'b0, l0, l1, d0, c0);
        chk("den_next_cycle", d0, 1);
        rd(32'h0300, 32'h10, 2'b00, 0);
        rd(32'h0100, 32'h1, 2'b00, 0);

        // Kick pulse width.
        wr(32'h0200, 32'h1, 4'hF, 2'b00, 0, 1'b0, l0, l1, d0, c0);
        chk("live_pulse_hi", l0, 1);
        chk("live_pulse_lo", l1, 0);
        chk("live_idle", WDLIVE, 0);
        wr(32'h0200, 32'h0, 4'hF, 2'b00, 0, 1'b0, l0, l1, d0, c0);
        chk("live0_no_pulse_a", l0, 0);
        chk("live0_no_pulse_b", l1, 0);

        // Sticky timeout and W1C.
        @(negedge clk);
        chk("irq_before_wto", IRQ, 0);
        WTO = 1'b1;
        @(negedge clk);
        WTO = 1'b0;
        chk("irq_set", IRQ, 1);
        repeat (3) @(negedge clk);
        chk("irq_sticky", IRQ, 1);
        rd(32'h0400, 32'h1, 2'b00, 0);
        wr(32'h0400, 32'h1, 4'hF, 2'b00, 0, 1'b0, l0, l1, d0, c0);
        chk("irq_cleared", IRQ, 0);
        rd(32'h0400, 32'h0, 2'b00, 0);
        wr(32'h0400, 32'h1, 4'hF, 2'b00, 0, 1'b1, l0, l1, d0, c0);
        chk("irq_set_wins", IRQ, 1);
        rd(32'h0400, 32'h1, 2'b00, 0);

        // Byte-strobe partial count update.
        wr(32'h0300, 32'h1122_3344, 4'hF, 2'b00, 0, 1'b0, l0, l1, d0, c0);
        wr(32'h0300, 32'hAABB_CCDD, 4'b0101, 2'b00, 0, 1'b0, l0, l1, d0, c0);
        chk("cnt_partial", WTOCNT, 32'h11BB_33DD);
        rd(32'h0300, 32'h11BB_33DD, 2'b00, 0);

        // Unmapped address with response backpressure.
        wr(32'h0500, 32'hFFFF_FFFF, 4'hF, 2'b11, 5, 1'b0, l0, l1, d0, c0);
        rd(32'h0500, 32'h0, 2'b11, 5);
        chk("decerr_cnt_kept", WTOCNT, 32'h11BB_33DD);
        chk("decerr_en_kept", WDEN, 1);
        chk("decerr_irq_kept", IRQ, 1);

        // Disable again.
        wr(32'h0100, 32'h0, 4'hF, 2'b00, 0, 1'b0, l0, l1, d0, c0);
        chk("den_off", WDEN, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
